mem_port_arbiter: RTL

//   Shares the single memory port between instruction fetch (control-unit FETCH state) and data

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data load/store
//
// Ports:
//   clk, reset                      rising-edge clock, asynchronous active-low reset
//   if_req, if_addr                 fetch request (read only), held until if_ack
//   if_ack, if_rdata                one-cycle completion pulse, fetched word (held)
//   d_req, d_we, d_addr, d_wdata    data load/store request, held until d_ack
//   d_ack, d_rdata                  one-cycle completion pulse, load result (loads only)
//   mem_addr, mem_wdata, mem_we     registered memory request, write pulses one cycle
//   mem_rdata                       memory read data, valid MEM_LAT cycles after mem_addr
//   busy                            high whenever an access is in progress
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             owner_d;       // 1 = data port owns the current access
    logic             last_owner_d;  // owner of the most recent grant, for round robin
    logic             we_r;
    logic [CNT_W-1:0] cnt;
    logic             any_req;
    logic             grant_d;

    // On a tie the port that did not win last time gets the grant. last_owner
    // resets to fetch, so the first tie after reset goes to the data port.
    assign any_req = if_req | d_req;
    assign grant_d = d_req & (~if_req | ~last_owner_d);

    always_comb begin
        state_next = state;
        if_ack     = 1'b0;
        d_ack      = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                if_ack     = ~owner_d;
                d_ack      = owner_d;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            owner_d      <= 1'b0;
            last_owner_d <= 1'b0;
            we_r         <= 1'b0;
            cnt          <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
        end else begin
            state  <= state_next;
            // Write enable is a single pulse in the first ACCESS cycle only.
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_d      <= grant_d;
                        last_owner_d <= grant_d;
                        we_r         <= grant_d & d_we;
                        mem_we       <= grant_d & d_we;
                        cnt          <= CNT_W'(MEM_LAT - 1);
                        mem_addr     <= grant_d ? d_addr : if_addr;
                        if (grant_d) begin
                            mem_wdata <= d_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (!owner_d) begin
                            if_rdata <= mem_rdata;
                        end else if (!we_r) begin
                            d_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
